rx_packet_parser: RTL and testbench

Byte-level framing stage directly downstream of the UART receiver. Consumes one received byte per `rx_valid` strobe and assembles framed command packets (sync, command, length, payload, XOR checksum). Presents each verified packet on a valid/ready output port to the command-handling logic. Flags checksum, length, overrun and inter-byte timeout errors as single-cycle pulses.

---
 rtl/rx_packet_parser_if.sv | 28 ++
 rtl/rx_packet_parser.sv | 145 ++++++++++++++
 tb/tb_rx_packet_parser.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_packet_parser_if.sv
// rx_packet_parser_if
//   Packet output channel of the receive framing stage (valid/ready).
//   master : producer side (drives the packet fields and pkt_valid, samples pkt_ready)
//   slave  : consumer side (samples the packet fields and pkt_valid, drives pkt_ready)
//   pkt_cmd     8        command byte of the presented packet
//   pkt_len     4        payload length of the presented packet
//   pkt_payload 8*MAX_LEN payload, byte i at [8i+7:8i], bytes >= pkt_len are 0
//   pkt_valid   1        packet available
//   pkt_ready   1        consumer accepts the packet
interface rx_packet_parser_if #(
  parameter int MAX_LEN = 8
);
  logic [7:0]           pkt_cmd;
  logic [3:0]           pkt_len;
  logic [8*MAX_LEN-1:0] pkt_payload;
  logic                 pkt_valid;
  logic                 pkt_ready;

  modport master (
    output pkt_cmd, pkt_len, pkt_payload, pkt_valid,
    input  pkt_ready
  );

  modport slave (
    input  pkt_cmd, pkt_len, pkt_payload, pkt_valid,
    output pkt_ready
  );
endinterface

// File: rtl/rx_packet_parser.sv
// rx_packet_parser
//   Byte-level framing stage behind the UART receiver. Assembles
//   SYNC, CMD, LEN, payload[LEN], CSUM frames (CSUM = CMD ^ LEN ^ payload)
//   and presents verified packets on a valid/ready channel. Errors are
//   reported as registered single-cycle pulses.
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   rx_data      received byte
//   rx_valid     one-cycle strobe, rx_data holds a new byte
//   pkt          packet output channel (master modport)
//   err_checksum checksum mismatch, packet dropped
//   err_length   length byte > MAX_LEN, packet dropped
//   err_overrun  good packet dropped, output still occupied
//   err_timeout  inter-byte timeout, partial packet dropped
module rx_packet_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 8,
  parameter int         TIMEOUT   = 50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  rx_packet_parser_if.master        pkt,
  output logic                      err_checksum,
  output logic                      err_length,
  output logic                      err_overrun,
  output logic                      err_timeout
);

  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t               state;
  logic [7:0]           asm_cmd;
  logic [3:0]           asm_len;
  logic [8*MAX_LEN-1:0] asm_pay;
  logic [3:0]           idx;
  logic [7:0]           csum;
  logic [15:0]          to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      asm_cmd         <= '0;
      asm_len         <= '0;
      asm_pay         <= '0;
      idx             <= '0;
      csum            <= '0;
      to_cnt          <= '0;
      pkt.pkt_cmd     <= '0;
      pkt.pkt_len     <= '0;
      pkt.pkt_payload <= '0;
      pkt.pkt_valid   <= 1'b0;
      err_checksum    <= 1'b0;
      err_length      <= 1'b0;
      err_overrun     <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;

      // Consumer handshake; a commit further down in this cycle overrides it.
      if (pkt.pkt_valid && pkt.pkt_ready) begin
        pkt.pkt_valid <= 1'b0;
      end

      // Inter-byte silence counter, only meaningful while inside a frame.
      if (rx_valid || state == S_IDLE) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 16'd1;
      end

      // A byte arriving on the expiry cycle wins over the timeout.
      if (!rx_valid && state != S_IDLE && to_cnt == TO_LAST) begin
        state       <= S_IDLE;
        to_cnt      <= '0;
        err_timeout <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= S_CMD;
            end
          end
          S_CMD: begin
            asm_cmd <= rx_data;
            asm_pay <= '0;
            csum    <= rx_data;
            state   <= S_LEN;
          end
          S_LEN: begin
            if (rx_data > MAX_LEN_B) begin
              err_length <= 1'b1;
              state      <= S_IDLE;
            end else begin
              asm_len <= rx_data[3:0];
              csum    <= csum ^ rx_data;
              idx     <= '0;
              state   <= (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) begin
                asm_pay[8*i +: 8] <= rx_data;
              end
            end
            csum <= csum ^ rx_data;
            idx  <= idx + 4'd1;
            if (idx == asm_len - 4'd1) begin
              state <= S_CSUM;
            end
          end
          S_CSUM: begin
            state <= S_IDLE;
            if (rx_data != csum) begin
              err_checksum <= 1'b1;
            end else if (!pkt.pkt_valid || pkt.pkt_ready) begin
              pkt.pkt_cmd     <= asm_cmd;
              pkt.pkt_len     <= asm_len;
              pkt.pkt_payload <= asm_pay;
              pkt.pkt_valid   <= 1'b1;
            end else begin
              err_overrun <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_parser.sv
// tb_rx_packet_parser
//   Bench for rx_packet_parser with MAX_LEN=8, TIMEOUT=8. A byte-stream
//   reference model (frame bytes collected in a queue, checksum as XOR over
//   the whole frame) predicts every output each cycle; directed sequences
//   add literal expectations, then randomized frames exercise the rest.
module tb_rx_packet_parser;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_LEN = 8;
  localparam int         TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       pkt_ready = 1'b0;
  logic       err_checksum, err_length, err_overrun, err_timeout;
  bit         rand_rdy = 1'b0;

  int nvec = 0;
  int nerr = 0;

  rx_packet_parser_if #(.MAX_LEN(MAX_LEN)) pif ();
  assign pif.pkt_ready = pkt_ready;

  rx_packet_parser #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .pkt(pif),
    .err_checksum(err_checksum),
    .err_length(err_length),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit                   in_pkt;
  int                   idle;
  logic [7:0]           pb[$];
  logic [7:0]           e_cmd;
  logic [3:0]           e_len;
  logic [8*MAX_LEN-1:0] e_pay;
  logic                 e_valid, e_ec, e_el, e_eo, e_et;

  task automatic model_clear();
    in_pkt = 0; idle = 0; pb.delete();
    e_cmd = '0; e_len = '0; e_pay = '0; e_valid = 0;
    e_ec = 0; e_el = 0; e_eo = 0; e_et = 0;
  endtask

  task automatic model_step();
    logic       old_valid;
    logic [7:0] x;
    old_valid = e_valid;
    e_ec = 0; e_el = 0; e_eo = 0; e_et = 0;
    if (e_valid && pkt_ready) e_valid = 0;
    if (!rx_valid) begin
      if (in_pkt) begin
        idle++;
        if (idle == TIMEOUT) begin e_et = 1; in_pkt = 0; idle = 0; end
      end
    end else begin
      idle = 0;
      if (!in_pkt) begin
        if (rx_data == SYNC) begin in_pkt = 1; pb.delete(); end
      end else begin
        pb.push_back(rx_data);
        if (pb.size() == 2 && int'(pb[1]) > MAX_LEN) begin
          e_el = 1; in_pkt = 0;
        end else if (pb.size() >= 2 && pb.size() == int'(pb[1]) + 3) begin
          in_pkt = 0;
          x = 8'h00;
          foreach (pb[i]) x ^= pb[i];
          if (x != 8'h00) e_ec = 1;
          else if (!old_valid || pkt_ready) begin
            e_cmd = pb[0];
            e_len = pb[1][3:0];
            e_pay = '0;
            for (int i = 0; i < int'(pb[1]); i++) e_pay[8*i +: 8] = pb[2+i];
            e_valid = 1;
          end else e_eo = 1;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("pkt_valid",    64'(pif.pkt_valid),   64'(e_valid));
      check("pkt_cmd",      64'(pif.pkt_cmd),     64'(e_cmd));
      check("pkt_len",      64'(pif.pkt_len),     64'(e_len));
      check("pkt_payload",  64'(pif.pkt_payload), 64'(e_pay));
      check("err_checksum", 64'(err_checksum),    64'(e_ec));
      check("err_length",   64'(err_length),      64'(e_el));
      check("err_overrun",  64'(err_overrun),     64'(e_eo));
      check("err_timeout",  64'(err_timeout),     64'(e_et));
    end
  end

  task automatic tick();
    if (rand_rdy) pkt_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic drain();
    pkt_ready = 1'b1; tick(); pkt_ready = 1'b0; tick();
  endtask

  task automatic rand_frame();
    int         kind, len, gap;
    logic [7:0] cmd, lb, cs;
    logic [7:0] q[$];
    kind = $urandom_range(0, 19);
    if (kind == 0) begin
      repeat ($urandom_range(1, 3)) q.push_back(8'($urandom_range(0, 255)));
    end else begin
      cmd = 8'($urandom_range(0, 255));
      len = $urandom_range(0, MAX_LEN);
      lb  = (kind == 1) ? 8'($urandom_range(MAX_LEN + 1, 255)) : 8'(len);
      q.push_back(SYNC); q.push_back(cmd); q.push_back(lb);
      cs = cmd ^ lb;
      if (kind != 1) begin
        for (int i = 0; i < len; i++) begin
          q.push_back(8'($urandom_range(0, 255)));
          cs ^= q[q.size()-1];
        end
        if (kind == 2) cs ^= 8'(1 << $urandom_range(0, 7));
        q.push_back(cs);
      end
    end
    foreach (q[i]) begin
      send(q[i]);
      gap = $urandom_range(0, 59);
      if (gap < 42) gap = 0;
      else if (gap < 57) gap = $urandom_range(1, TIMEOUT - 1);
      else gap = $urandom_range(TIMEOUT, TIMEOUT + 3);
      repeat (gap) tick();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(pif.pkt_valid), 64'd0);
    reset_n = 1'b1;
    tick();

    // Basic packet, held until accepted
    send_q('{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h11});
    check("t1_valid", 64'(pif.pkt_valid), 64'd1);
    check("t1_cmd", 64'(pif.pkt_cmd), 64'h10);
    check("t1_len", 64'(pif.pkt_len), 64'd2);
    check("t1_payload", 64'(pif.pkt_payload), 64'h0000_0000_0000_0201);
    tick(); tick();
    check("t1_hold", 64'(pif.pkt_valid), 64'd1);
    pkt_ready = 1'b1; tick(); pkt_ready = 1'b0;
    check("t1_release", 64'(pif.pkt_valid), 64'd0);

    // Garbage then zero-length packet
    send_q('{8'h00, 8'hFF, 8'hA5, 8'h22, 8'h00, 8'h22});
    check("t2_cmd", 64'(pif.pkt_cmd), 64'h22);
    check("t2_payload", 64'(pif.pkt_payload), 64'h0);
    drain();

    // Bad checksum, then good packet
    send_q('{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h12});
    check("t3_err_csum", 64'(err_checksum), 64'd1);
    check("t3_no_valid", 64'(pif.pkt_valid), 64'd0);
    send_q('{8'hA5, 8'h44, 8'h01, 8'hA5, 8'hE0});
    check("t3_next_cmd", 64'(pif.pkt_cmd), 64'h44);
    check("t3_next_pay", 64'(pif.pkt_payload), 64'h0000_0000_0000_00A5);
    drain();

    // Oversize length, then hunt for sync
    send_q('{8'hA5, 8'h33, 8'h09});
    check("t4_err_len", 64'(err_length), 64'd1);
    send_q('{8'h55, 8'hA5, 8'h01, 8'h00, 8'h01});
    check("t4_resync", 64'(pif.pkt_cmd), 64'h01);
    drain();

    // Overrun, then replacement on the accept cycle
    send_q('{8'hA5, 8'h0A, 8'h00, 8'h0A});
    send_q('{8'hA5, 8'h0B, 8'h00, 8'h0B});
    check("t5_overrun", 64'(err_overrun), 64'd1);
    check("t5_kept", 64'(pif.pkt_cmd), 64'h0A);
    send_q('{8'hA5, 8'h0C, 8'h00});
    pkt_ready = 1'b1; send(8'h0C); pkt_ready = 1'b0;
    check("t5_replace", 64'(pif.pkt_cmd), 64'h0C);
    check("t5_still_valid", 64'(pif.pkt_valid), 64'd1);
    drain();

    // Timeout: fires on the 8th silent edge; 7 silent cycles are tolerated
    send_q('{8'hA5, 8'h10});
    repeat (TIMEOUT - 1) tick();
    check("t6_no_to_yet", 64'(err_timeout), 64'd0);
    tick();
    check("t6_timeout", 64'(err_timeout), 64'd1);
    send_q('{8'hA5, 8'h10, 8'h01});
    repeat (TIMEOUT - 1) tick();
    send_q('{8'h07, 8'h16});
    check("t6_slow_ok", 64'(pif.pkt_payload), 64'h07);

    // Reset mid-payload with a packet pending
    send_q('{8'hA5, 8'h10, 8'h04, 8'h01, 8'h02});
    #1 reset_n = 1'b0;
    #1 check("t7_rst_valid", 64'(pif.pkt_valid), 64'd0);
    check("t7_rst_payload", 64'(pif.pkt_payload), 64'd0);
    @(negedge clk);
    send(8'hA5);
    reset_n = 1'b1;
    repeat (TIMEOUT + 2) tick();

    // Randomized frames with random consumer back-pressure
    rand_rdy = 1'b1;
    repeat (400) rand_frame();
    rand_rdy = 1'b0;
    repeat (TIMEOUT + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
